// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_ID_EN to prefix every grant with header byte {5'b10100, grant_id}.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 i_uclk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_busy,
  output logic                 o_grant_valid,
  output logic [2:0]           o_grant_id
);

  // IDLE arbitrate | GRANT latch owner | ID header | LOAD take byte | START pulse | ACK await busy | DONE await idle
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ID, S_LOAD, S_START, S_ACK, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_ptr;
  logic [2:0]  r_win;
  logic [2:0]  r_grant_id;
  logic        r_grant_valid;
  logic [7:0]  r_tx_data;
  logic        r_last;
  logic        r_hdr;
  logic [7:0]  r_burst_cnt;
  logic [1:0]  r_ack_cnt;

  logic [2:0]  w_win;
  logic        w_any;
  logic        w_sel_valid;
  logic [7:0]  w_sel_data;
  logic        w_sel_last;
  logic        w_release;

  // Descending scan so the smallest offset after r_ptr is the last (winning) assignment.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (((int'(r_ptr) + k) == j || (int'(r_ptr) + k) == (j + NUM_REQ)) && i_req_valid[j]) begin
          w_win = 3'(j);
          w_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    o_req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant_id == 3'(j)) begin
        w_sel_valid    = i_req_valid[j];
        w_sel_data     = i_req_data[8*j +: 8];
        w_sel_last     = i_req_last[j];
        o_req_ready[j] = (r_state == S_LOAD);
      end
    end
  end

  assign w_release = r_last || (r_burst_cnt == 8'(MAX_BURST));

  always_ff @(posedge i_uclk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_tx_start = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_GRANT;
`ifdef UART_ARB_ID_EN
      S_GRANT: w_next = S_ID;
      S_ID:    w_next = S_START;
`else
      S_GRANT: w_next = S_LOAD;
`endif
      S_LOAD:  w_next = w_sel_valid ? S_START : S_IDLE;
      S_START: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          w_next     = S_ACK;
        end
      end
      S_ACK: begin
        if (i_tx_busy)               w_next = S_DONE;
        else if (r_ack_cnt == 2'd3)  w_next = S_START;
      end
      S_DONE: begin
        if (!i_tx_busy) w_next = (!r_hdr && w_release) ? S_IDLE : S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_uclk) begin
    if (i_rst) begin
      r_ptr         <= 3'(NUM_REQ - 1);
      r_win         <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_tx_data     <= '0;
      r_last        <= 1'b0;
      r_hdr         <= 1'b0;
      r_burst_cnt   <= '0;
      r_ack_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_win <= w_win;
        S_GRANT: begin
          r_grant_id    <= r_win;
          r_grant_valid <= 1'b1;
          r_burst_cnt   <= '0;
          r_hdr         <= 1'b0;
        end
`ifdef UART_ARB_ID_EN
        S_ID: begin
          r_tx_data <= {5'b10100, r_grant_id};
          r_hdr     <= 1'b1;
        end
`endif
        S_LOAD: begin
          if (w_sel_valid) begin
            r_tx_data <= w_sel_data;
            r_last    <= w_sel_last;
            if (r_burst_cnt < 8'(MAX_BURST)) r_burst_cnt <= r_burst_cnt + 8'd1;
          end else begin
            r_ptr         <= r_grant_id;
            r_grant_valid <= 1'b0;
          end
        end
        S_START: r_ack_cnt <= '0;
        S_ACK:   if (!i_tx_busy) r_ack_cnt <= r_ack_cnt + 2'd1;
        S_DONE: begin
          if (!i_tx_busy) begin
            if (r_hdr) begin
              r_hdr <= 1'b0;
            end else if (w_release) begin
              r_ptr         <= r_grant_id;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requesters feed byte queues, a monitor checks each tx_start.
// Expected (owner, byte) order is hand-derived per test; a transmitter model drives tx_busy.
module tb_uart_tx_arbiter;
  localparam int NREQ     = 4;
  localparam int BUSY_CYC = 40;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            grant_valid;
  logic [2:0]      grant_id;

  logic [8:0]  rq [NREQ][$];
  logic [10:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;
  int busy_mode = 0;
  int cyc = 0;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(16)) dut (
    .i_uclk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_grant_valid(grant_valid),
    .o_grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_req(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic sb_push(input int id, input logic [7:0] d);
    sb.push_back({3'(id), d});
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (k < 4000 && !(sb.size() == 0 && all_empty() && !grant_valid && !tx_busy)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) begin
      n_checks++;
      $display("FAIL %s: not idle within 4000 cycles, sb left %0d", nm, sb.size());
    end
  endtask

  task automatic wait_start(input string nm, output int t);
    int k = 0;
    @(negedge clk);
    while (!tx_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!tx_start) begin
      n_checks++;
      $display("FAIL %s: no tx_start within 100 cycles", nm);
    end
    t = cyc;
  endtask

  // Requester driver: accepted bytes leave the queue just after the accepting edge.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy from the cycle after tx_start; mode 1 never answers.
  initial begin
    logic [7:0] cap;
    bit chg;
    bit rs;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && busy_mode == 0) begin
        cap = tx_data;
        chg = 1'b0;
        rs  = 1'b0;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY_CYC) begin
          @(negedge clk);
          if (rst) rs = 1'b1;
          if (tx_data !== cap) chg = 1'b1;
        end
        @(posedge clk);
        #1 tx_busy = 1'b0;
        if (!rs) chk("tx_data_stable", 32'(chg), 32'd0);
      end
    end
  end

  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_start) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx_start: got data %0h id %0d, expected none", tx_data, grant_id);
        end else begin
          e = sb.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("grant_id", 32'(grant_id), 32'(e[10:8]));
          chk("grant_valid", 32'(grant_valid), 32'd1);
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // T1: single byte from requester 0
    push_req(0, 8'h55, 1'b1);
    sb_push(0, 8'h55);
    wait_idle("t1");
    chk("t1_grant_released", 32'(grant_valid), 32'd0);
    chk("t1_grant_id_held", 32'(grant_id), 32'd0);

    // T2: all four valid after reset (ptr=3) -> 0,1,2,3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) push_req(i, 8'(i + 1), 1'b1);
    for (int i = 0; i < NREQ; i++) sb_push(i, 8'(i + 1));
    wait_idle("t2");

    // T3: 20-byte message from 2 split by MAX_BURST, requester 1 slots in between
    for (int b = 1; b <= 20; b++) push_req(2, 8'(8'h10 + b), (b == 20));
    for (int b = 1; b <= 16; b++) sb_push(2, 8'(8'h10 + b));
    sb_push(1, 8'hE1);
    for (int b = 17; b <= 20; b++) sb_push(2, 8'(8'h10 + b));
    k = 0;
    while (!grant_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t3_req2_granted", 32'(grant_id), 32'd2);
    push_req(1, 8'hE1, 1'b1);
    wait_idle("t3");

    // T4: requester 0 stops after 2 of 3 bytes; requester 1 gets the next grant
    push_req(0, 8'hC1, 1'b0);
    push_req(0, 8'hC2, 1'b0);
    push_req(1, 8'hD1, 1'b1);
    sb_push(0, 8'hC1);
    sb_push(0, 8'hC2);
    sb_push(1, 8'hD1);
    wait_idle("t4");
    chk("t4_last_owner", 32'(grant_id), 32'd1);

    // T5: no busy response -> tx_start retried every 5 cycles, then reset inside DONE
    busy_mode = 1;
    push_req(3, 8'h77, 1'b1);
    for (int i = 0; i < 4; i++) sb_push(3, 8'h77);
    wait_start("t5_p0", t0);
    wait_start("t5_p1", t1);
    wait_start("t5_p2", t2);
    chk("t5_retry_gap1", 32'(t1 - t0), 32'd5);
    chk("t5_retry_gap2", 32'(t2 - t1), 32'd5);
    @(posedge clk);
    busy_mode = 0;
    wait_start("t5_p3", t3);
    chk("t5_retry_gap3", 32'(t3 - t2), 32'd5);
    k = 0;
    while (!tx_busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t5_busy_seen", 32'(tx_busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t5_rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;
    wait_idle("t5");

    // T6: requester 3 sends 0xAB, with header 0xA3 when the ID feature is built in
    push_req(3, 8'hAB, 1'b1);
`ifdef UART_ARB_ID_EN
    sb_push(3, 8'hA3);
`endif
    sb_push(3, 8'hAB);
    wait_idle("t6");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
